// File: rtl/read_return_buffer_pkg.sv
// Shared types for the read return buffer: data width, tag sizing and per-slot status bits.
package read_return_buffer_pkg;

  localparam int unsigned data_width       = 32;
  localparam int unsigned read_entries_log = 4;
  localparam int unsigned RRB_ENTRIES      = 1 << read_entries_log;

  typedef struct packed {
    logic alloc;
    logic filled;
  } rrb_slot_t;

endpackage

// File: rtl/rrb_slot_store.sv
// Slot storage: data array plus alloc/filled bits, one fill write port and one head read port.
import read_return_buffer_pkg::*;

module rrb_slot_store #(
  parameter int unsigned ENTRIES = RRB_ENTRIES,
  parameter int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned DATA_W  = data_width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en,
  input  logic [IDX_W-1:0]  alloc_idx,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              drain_en,
  input  logic [IDX_W-1:0]  head_idx,
  output rrb_slot_t         fill_slot,
  output rrb_slot_t         head_slot,
  output logic [DATA_W-1:0] head_data
);

  rrb_slot_t         slots [ENTRIES];
  logic [DATA_W-1:0] data  [ENTRIES];

  // Alloc (tail) and drain (head) never target the same slot; a fill never hits a draining slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        slots[i] <= '0;
        data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (alloc_en && alloc_idx == IDX_W'(i)) begin
          slots[i].alloc  <= 1'b1;
          slots[i].filled <= 1'b0;
        end
        if (fill_en && fill_idx == IDX_W'(i)) begin
          slots[i].filled <= 1'b1;
          data[i]         <= fill_data;
        end
        if (drain_en && head_idx == IDX_W'(i)) begin
          slots[i] <= '0;
        end
      end
    end
  end

  // Compare-based lookup so an out-of-range fill index reads back as an unallocated slot.
  always_comb begin
    fill_slot = '0;
    head_slot = '0;
    head_data = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (fill_idx == IDX_W'(i)) fill_slot = slots[i];
      if (head_idx == IDX_W'(i)) begin
        head_slot = slots[i];
        head_data = data[i];
      end
    end
  end

endmodule

// File: rtl/read_return_buffer.sv
// In-order read return buffer: issues tags, accepts out-of-order fills, returns data in tag order.
// Optional RRB_FILL_BYPASS_EN presents a fill to the unfilled head slot in the same cycle.
import read_return_buffer_pkg::*;

module read_return_buffer #(
  parameter int unsigned READ_ENTRIES = RRB_ENTRIES,
  parameter int unsigned IDX_W        = $clog2(READ_ENTRIES),
  parameter int unsigned DATA_W       = data_width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic [IDX_W-1:0]  alloc_index_o,
  input  logic              fill_valid_i,
  input  logic [IDX_W-1:0]  fill_index_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_err_o,
  output logic              resp_valid_o,
  output logic [IDX_W-1:0]  resp_index_o,
  output logic [DATA_W-1:0] resp_data_o,
  input  logic              resp_ready_i,
  output logic [IDX_W:0]    count_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(READ_ENTRIES - 1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(READ_ENTRIES);

  logic [IDX_W-1:0]  head, tail;
  logic [IDX_W:0]    count;
  logic              fill_err_q;
  rrb_slot_t         fill_slot, head_slot;
  logic [DATA_W-1:0] head_data;
  logic              alloc_fire, fill_legal, drain_fire, bypass_hit, store_fill;

  rrb_slot_store #(
    .ENTRIES (READ_ENTRIES),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_fire),
    .alloc_idx (tail),
    .fill_en   (store_fill),
    .fill_idx  (fill_index_i),
    .fill_data (fill_data_i),
    .drain_en  (drain_fire),
    .head_idx  (head),
    .fill_slot (fill_slot),
    .head_slot (head_slot),
    .head_data (head_data)
  );

  // Legality, handshakes and head presentation.
  always_comb begin
    alloc_ready_o = !rst && (count < FULL_CNT);
    alloc_index_o = tail;
    alloc_fire    = alloc_valid_i && alloc_ready_o;
    fill_legal    = !rst && fill_valid_i && ({1'b0, fill_index_i} < FULL_CNT)
                    && fill_slot.alloc && !fill_slot.filled;
`ifdef RRB_FILL_BYPASS_EN
    bypass_hit    = fill_legal && (fill_index_i == head);
`else
    bypass_hit    = 1'b0;
`endif
    resp_valid_o  = !rst && ((head_slot.alloc && head_slot.filled) || bypass_hit);
    resp_index_o  = head;
    resp_data_o   = rst ? '0 : (bypass_hit ? fill_data_i : head_data);
    drain_fire    = resp_valid_o && resp_ready_i;
    store_fill    = fill_legal && !(bypass_hit && resp_ready_i);
    fill_err_o    = fill_err_q && !rst;
    count_o       = rst ? '0 : count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fill_err_q <= 1'b0;
    end else begin
      fill_err_q <= fill_valid_i && !fill_legal;
      if (alloc_fire) tail <= (tail == LAST_IDX) ? '0 : tail + IDX_W'(1);
      if (drain_fire) head <= (head == LAST_IDX) ? '0 : head + IDX_W'(1);
      case ({alloc_fire, drain_fire})
        2'b10:   count <= count + (IDX_W + 1)'(1);
        2'b01:   count <= count - (IDX_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_read_return_buffer.sv
// Scoreboard bench for read_return_buffer with 12 entries (non power of two).
module tb_read_return_buffer;

  localparam int unsigned N  = 12;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid_i;
  logic          alloc_ready_o;
  logic [IW-1:0] alloc_index_o;
  logic          fill_valid_i;
  logic [IW-1:0] fill_index_i;
  logic [DW-1:0] fill_data_i;
  logic          fill_err_o;
  logic          resp_valid_o;
  logic [IW-1:0] resp_index_o;
  logic [DW-1:0] resp_data_o;
  logic          resp_ready_i;
  logic [IW:0]   count_o;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  read_return_buffer #(.READ_ENTRIES(N), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_index_o (alloc_index_o),
    .fill_valid_i  (fill_valid_i),
    .fill_index_i  (fill_index_i),
    .fill_data_i   (fill_data_i),
    .fill_err_o    (fill_err_o),
    .resp_valid_o  (resp_valid_o),
    .resp_index_o  (resp_index_o),
    .resp_data_o   (resp_data_o),
    .resp_ready_i  (resp_ready_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [IW-1:0] idx, input logic [DW-1:0] d);
    fill_valid_i = 1'b1;
    fill_index_i = idx;
    fill_data_i  = d;
  endtask

  task automatic push(input logic [IW-1:0] idx, input logic [DW-1:0] d);
    resp_t r;
    r.idx  = idx;
    r.data = d;
    exp_q.push_back(r);
  endtask

  // Monitor: every accepted response must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && resp_valid_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid_o), 64'(0));
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_index", 64'(resp_index_o), 64'(e.idx));
        check("resp_data", 64'(resp_data_o), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; alloc_valid_i = 1'b0; fill_valid_i = 1'b0;
    fill_index_i = '0; fill_data_i = '0; resp_ready_i = 1'b0;
    tick(); tick();
    check("rst_alloc_ready", 64'(alloc_ready_o), 64'(0));
    check("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_fill_err", 64'(fill_err_o), 64'(0));
    check("rst_resp_data", 64'(resp_data_o), 64'(0));
    rst = 1'b0;
    tick();
    check("post_rst_alloc_ready", 64'(alloc_ready_o), 64'(1));
    check("post_rst_count", 64'(count_o), 64'(0));

    // Three allocations
    alloc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("alloc_index", 64'(alloc_index_o), 64'(i));
      tick();
    end
    alloc_valid_i = 1'b0;
    check("count_3", 64'(count_o), 64'(3));
    check("empty_resp_valid", 64'(resp_valid_o), 64'(0));

    // Out-of-order fills, in-order responses
    push(0, 32'hA); push(1, 32'hB); push(2, 32'hC);
    resp_ready_i = 1'b1;
    fill(2, 32'hC); tick();
    fill(1, 32'hB); tick();
    fill(0, 32'hA); tick();
    fill_valid_i = 1'b0;
    tick(); tick(); tick();
    check("ooo_count_zero", 64'(count_o), 64'(0));
    check("ooo_resp_valid", 64'(resp_valid_o), 64'(0));
    check("ooo_fill_err", 64'(fill_err_o), 64'(0));
    resp_ready_i = 1'b0;

    // Full and wrap
    rst = 1'b1; tick(); rst = 1'b0; tick();
    alloc_valid_i = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      check("full_alloc_index", 64'(alloc_index_o), 64'(i));
      tick();
    end
    check("full_count", 64'(count_o), 64'(N));
    check("full_alloc_ready", 64'(alloc_ready_o), 64'(0));
    check("full_wrap_index", 64'(alloc_index_o), 64'(0));
    tick();
    check("full_refuse_count", 64'(count_o), 64'(N));
    push(0, 32'h100);
    resp_ready_i = 1'b1;
    fill(0, 32'h100); tick();
    fill_valid_i = 1'b0;
`ifndef RRB_FILL_BYPASS_EN
    check("full_fill_count", 64'(count_o), 64'(N));
    check("full_fill_resp_valid", 64'(resp_valid_o), 64'(1));
    check("full_fill_alloc_ready", 64'(alloc_ready_o), 64'(0));
    tick();
`endif
    resp_ready_i = 1'b0;
    check("full_drain_no_alloc", 64'(count_o), 64'(N - 1));
    check("drain_alloc_ready", 64'(alloc_ready_o), 64'(1));
    check("wrap_tag", 64'(alloc_index_o), 64'(0));
    tick();
    alloc_valid_i = 1'b0;
    check("refill_count", 64'(count_o), 64'(N));
    check("refill_next_tag", 64'(alloc_index_o), 64'(1));

    // Illegal fills
    rst = 1'b1; tick(); rst = 1'b0; tick();
    alloc_valid_i = 1'b1; tick(); alloc_valid_i = 1'b0;
    fill(0, 32'hA5); tick(); fill_valid_i = 1'b0;
    check("head_valid", 64'(resp_valid_o), 64'(1));
    check("head_data", 64'(resp_data_o), 64'hA5);
    check("legal_fill_err", 64'(fill_err_o), 64'(0));
    fill(5, 32'h55); tick(); fill_valid_i = 1'b0;
    check("unalloc_fill_err", 64'(fill_err_o), 64'(1));
    check("unalloc_data_kept", 64'(resp_data_o), 64'hA5);
    tick();
    check("unalloc_err_pulse", 64'(fill_err_o), 64'(0));
    fill(0, 32'hFF); tick(); fill_valid_i = 1'b0;
    check("dup_fill_err", 64'(fill_err_o), 64'(1));
    check("dup_data_kept", 64'(resp_data_o), 64'hA5);
    tick();
    check("dup_err_pulse", 64'(fill_err_o), 64'(0));
    fill(14, 32'hEE); tick(); fill_valid_i = 1'b0;
    check("range_fill_err", 64'(fill_err_o), 64'(1));
    tick();
    check("range_err_pulse", 64'(fill_err_o), 64'(0));

    // Backpressure with concurrent allocate
    alloc_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      alloc_valid_i = 1'b0;
      check("bp_valid", 64'(resp_valid_o), 64'(1));
      check("bp_data", 64'(resp_data_o), 64'hA5);
      check("bp_index", 64'(resp_index_o), 64'(0));
      if (k == 0) check("bp_alloc_count", 64'(count_o), 64'(2));
    end
    alloc_valid_i = 1'b1;
    fill(2, 32'h33); tick();
    alloc_valid_i = 1'b0; fill_valid_i = 1'b0;
    check("alloc_fill_same_err", 64'(fill_err_o), 64'(1));
    check("alloc_fill_same_count", 64'(count_o), 64'(3));
    push(0, 32'hA5);
    resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
    check("bp_drain_count", 64'(count_o), 64'(2));
    check("bp_next_unfilled", 64'(resp_valid_o), 64'(0));

    // Reset with five outstanding tags
    alloc_valid_i = 1'b1; tick(); tick(); tick(); alloc_valid_i = 1'b0;
    check("outstanding_5", 64'(count_o), 64'(5));
    rst = 1'b1;
    #1;
    check("in_rst_count", 64'(count_o), 64'(0));
    check("in_rst_alloc_ready", 64'(alloc_ready_o), 64'(0));
    tick(); rst = 1'b0; tick();
    check("after_rst_count", 64'(count_o), 64'(0));
    check("after_rst_resp_valid", 64'(resp_valid_o), 64'(0));
    check("after_rst_tag", 64'(alloc_index_o), 64'(0));
    fill(1, 32'h11); tick(); fill_valid_i = 1'b0;
    check("stale_fill_err", 64'(fill_err_o), 64'(1));

    // Fill-to-head latency
    alloc_valid_i = 1'b1; tick(); alloc_valid_i = 1'b0;
    push(0, 32'h77);
    resp_ready_i = 1'b1;
    fill(0, 32'h77);
    #1;
`ifdef RRB_FILL_BYPASS_EN
    check("bypass_same_cycle", 64'(resp_valid_o), 64'(1));
    tick(); fill_valid_i = 1'b0;
    check("bypass_drained", 64'(count_o), 64'(0));
`else
    check("no_bypass_same_cycle", 64'(resp_valid_o), 64'(0));
    tick(); fill_valid_i = 1'b0;
    check("latency1_valid", 64'(resp_valid_o), 64'(1));
    check("latency1_count", 64'(count_o), 64'(1));
    tick();
    check("latency1_drained", 64'(count_o), 64'(0));
`endif
    resp_ready_i = 1'b0;
    tick(); tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
